dht11_start_ctrl: RTL and testbench
===================================

Name: dht11_start_ctrl

Overview:
Upstream sequencer for the DHT11 bit receiver. On a start request it drives the single-wire bus low for the 18 ms host start pulse, then releases it. It times the sensor's ~80 us low / ~80 us high response, then asserts en to the bit receiver for one frame window. It reports done, or an error with a cause code. Clocked at the shared 195.3125 kHz sensor clock (1 tick = 5.12 us).

Parameters:
START_LOW_TICKS, 3516, ticks the host holds the bus low (~18.0 ms)
RELEASE_MAX_TICKS, 8, max ticks after release before the sensor must pull low (~41 us)
RESP_MIN_TICKS, 12, min accepted length of each response phase (~61 us)
RESP_MAX_TICKS, 20, max accepted length of each response phase (~102 us)
FRAME_TICKS, 1000, ticks en is held for the 40-bit frame (~5.1 ms)
CNT_W, 12, tick counter width; must hold max(START_LOW_TICKS, FRAME_TICKS)

Ports:
clk  in  1  sensor-domain clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a read; sampled only in IDLE
dht11_data_s  in  1  synchronized bus level (1 = high/released)
dht11_drive_low  out  1  1 = top level drives bus to 0; 0 = bus released (tri-state)
en  out  1  enable to downstream bit receiver
busy  out  1  high from start acceptance until done/error cycle
done  out  1  one-cycle pulse, frame window completed
error  out  1  one-cycle pulse, handshake failed
err_code  out  2  0 none, 1 no response, 2 bad response-low, 3 bad response-high; held until next accepted start

Behaviour:
- All outputs registered. On rst_n=0 (async): state=IDLE, counter=0, and dht11_drive_low, en, busy, done, error, err_code all 0. A reset mid-operation releases the bus immediately, without waiting for clk.
- The counter counts clk cycles spent in the current phase. It is cleared to 0 on every state change unless stated otherwise.
- IDLE: start=1 -> START_LOW. Next cycle: dht11_drive_low=1, busy=1, err_code=0. start=0 -> stay.
- START_LOW: counter increments each cycle. At counter==START_LOW_TICKS-1 -> WAIT_RESP. dht11_drive_low is therefore high for exactly START_LOW_TICKS cycles.
- WAIT_RESP: bus released.
  - dht11_data_s==0 -> RESP_LOW, counter=1.
  - Otherwise counter increments. Reaching RELEASE_MAX_TICKS with the line still high -> ERROR, err_code=1.
- RESP_LOW: counter increments while dht11_data_s==0.
  - On dht11_data_s==1: counter in [RESP_MIN_TICKS, RESP_MAX_TICKS] -> RESP_HIGH with counter=1; otherwise -> ERROR, err_code=2.
  - counter exceeding RESP_MAX_TICKS while still low -> ERROR, err_code=2, without waiting for the edge.
- RESP_HIGH: same rule with polarity inverted.
  - Valid falling edge -> RECEIVE; en=1 from the next cycle. That edge is the start of bit 39's low period.
  - Out-of-range length -> ERROR, err_code=3.
- RECEIVE: en=1 and busy=1. The bus level is ignored. At counter==FRAME_TICKS-1 -> DONE, so en is high for exactly FRAME_TICKS cycles.
- DONE: en=0, done=1 for one cycle, busy=0 -> IDLE.
- ERROR: dht11_drive_low=0, en=0, error=1 for one cycle, busy=0 -> IDLE. err_code persists.
- start is ignored whenever state!=IDLE, including during the DONE/ERROR cycle. A start held high is accepted on the first IDLE cycle.
- dht11_drive_low and en are never high simultaneously. dht11_drive_low=1 only in START_LOW.
- The counter saturates and never wraps. Comparisons are unsigned at CNT_W bits.

Test Plan:
- Nominal: start pulse; model sensor low 16 ticks, high 16 ticks, then data -> drive_low high exactly 3516 cycles; en rises 1 cycle after the falling edge and stays 1000 cycles; done pulses once; err_code=0; busy low afterwards.
- No response: bus stays high after release -> error pulse 8 cycles after release, err_code=1, en never asserted.
- Short response-low: sensor low 5 ticks then high -> error on the rising-edge cycle, err_code=2. Stuck low: line never rises -> error when counter passes 20, err_code=2.
- Bad response-high: low 16 ticks, high 30 ticks -> error when counter passes 20 in RESP_HIGH, err_code=3.
- Async reset asserted mid-START_LOW (tick 1000) -> dht11_drive_low drops without a clk edge; all outputs 0. After release, a new start yields a full 3516-cycle pulse.
- start held high through a nominal read -> second read begins on the cycle after done. start pulses during busy -> ignored, exactly one done.

Source files
------------

// File: rtl/dht11_start_ctrl.sv
// dht11_start_ctrl
// Host-side start sequencer for a DHT11 single-wire sensor. On a start
// request it holds the bus low for the host start pulse, releases it, times
// the sensor's low/high response and then opens a fixed-length window (en)
// for the downstream bit receiver. It finishes with a one-cycle done pulse,
// or with a one-cycle error pulse and a cause code.
//
// Ports:
//   clk             sensor-domain clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           read request, sampled only while idle
//   dht11_data_s    synchronized bus level (1 = high / released)
//   dht11_drive_low 1 = drive bus to 0, 0 = release bus
//   en              enable to the bit receiver for one frame window
//   busy            high from start acceptance until the done/error cycle
//   done            one-cycle pulse, frame window completed
//   error           one-cycle pulse, handshake failed
//   err_code        0 none, 1 no response, 2 bad response-low,
//                   3 bad response-high; held until the next accepted start
module dht11_start_ctrl #(
  parameter int unsigned START_LOW_TICKS   = 3516,
  parameter int unsigned RELEASE_MAX_TICKS = 8,
  parameter int unsigned RESP_MIN_TICKS    = 12,
  parameter int unsigned RESP_MAX_TICKS    = 20,
  parameter int unsigned FRAME_TICKS       = 1000,
  parameter int unsigned CNT_W             = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht11_data_s,
  output logic       dht11_drive_low,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_RECEIVE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_LOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RELEASE_MAX = CNT_W'(RELEASE_MAX_TICKS);
  localparam logic [CNT_W-1:0] RESP_MIN    = CNT_W'(RESP_MIN_TICKS);
  localparam logic [CNT_W-1:0] RESP_MAX    = CNT_W'(RESP_MAX_TICKS);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_NO_RESP   = 2'd1;
  localparam logic [1:0] ERR_BAD_LOW   = 2'd2;
  localparam logic [1:0] ERR_BAD_HIGH  = 2'd3;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_ok;

  // Saturating increment: the phase counter never wraps.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Length of the response phase just ended is within the accepted window.
  assign len_ok = (cnt >= RESP_MIN) && (cnt <= RESP_MAX);

  // Sequencer with registered outputs; done/error default low so they pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      dht11_drive_low <= 1'b0;
      en              <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_code        <= ERR_NONE;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state           <= S_START_LOW;
            dht11_drive_low <= 1'b1;
            busy            <= 1'b1;
            err_code        <= ERR_NONE;
          end
        end

        S_START_LOW: begin
          if (cnt == START_LAST) begin
            state           <= S_WAIT_RESP;
            cnt             <= '0;
            dht11_drive_low <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Bus released; the first low sample already counts as one tick.
        S_WAIT_RESP: begin
          if (!dht11_data_s) begin
            state <= S_RESP_LOW;
            cnt   <= CNT_ONE;
          end else if (cnt_inc >= RELEASE_MAX) begin
            state    <= S_ERROR;
            cnt      <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_NO_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_RESP_LOW: begin
          if (dht11_data_s) begin
            if (len_ok) begin
              state <= S_RESP_HIGH;
              cnt   <= CNT_ONE;
            end else begin
              state    <= S_ERROR;
              cnt      <= '0;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_BAD_LOW;
            end
          end else if (cnt >= RESP_MAX) begin
            // Still low past the maximum: fail without waiting for the edge.
            state    <= S_ERROR;
            cnt      <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_BAD_LOW;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // The closing falling edge is the start of the first data bit.
        S_RESP_HIGH: begin
          if (!dht11_data_s) begin
            if (len_ok) begin
              state <= S_RECEIVE;
              cnt   <= '0;
              en    <= 1'b1;
            end else begin
              state    <= S_ERROR;
              cnt      <= '0;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_BAD_HIGH;
            end
          end else if (cnt >= RESP_MAX) begin
            state    <= S_ERROR;
            cnt      <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_BAD_HIGH;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Fixed frame window; bus level is the bit receiver's business.
        S_RECEIVE: begin
          if (cnt == FRAME_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end

        S_ERROR: begin
          state <= S_IDLE;
          cnt   <= '0;
        end

        default: begin
          state           <= S_IDLE;
          cnt             <= '0;
          dht11_drive_low <= 1'b0;
          en              <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_start_ctrl.sv
// Directed bench for dht11_start_ctrl: scripted sensor responses, cycle
// counts of drive_low/en windows and timing of done/error pulses.
module tb_dht11_start_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dht11_data_s;
  logic       dht11_drive_low;
  logic       en;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent run_read
  int drive_cnt, en_cnt, done_cnt, err_cnt, overlap_cnt;
  int rel_cyc, en_first, end_cyc;
  int busy_first, code_first, code_end, busy_end;
  int post_drive1, post_drive2, finished;

  localparam int NEVER = 100000;

  dht11_start_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dht11_data_s    (dht11_data_s),
    .dht11_drive_low (dht11_drive_low),
    .en              (en),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Issue a start and play a sensor that, counted from the first released
  // cycle, is low for low_len cycles, high for high_len cycles, then low.
  // mode 0: plain start pulse; 1: extra start pulses while busy and on the
  // done/error cycle; 2: start held high throughout.
  // Called and returns 1 time unit after a rising edge.
  task automatic run_read(input int low_len, input int high_len, input int mode);
    drive_cnt = 0; en_cnt = 0; done_cnt = 0; err_cnt = 0; overlap_cnt = 0;
    rel_cyc = -1; en_first = -1; end_cyc = -1;
    busy_first = -1; code_first = -1; code_end = -1; busy_end = -1;
    post_drive1 = -1; post_drive2 = -1; finished = 0;
    dht11_data_s = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    if (mode != 2) start = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (end_cyc >= 0) begin
        start = (mode == 2);
        dht11_data_s = 1'b1;
        if (cyc == end_cyc + 1) post_drive1 = dht11_drive_low;
        if (cyc == end_cyc + 2) begin
          post_drive2 = dht11_drive_low;
          finished = 1;
          break;
        end
      end else begin
        if (cyc == 0) begin
          busy_first = busy;
          code_first = err_code;
        end
        if (dht11_drive_low) drive_cnt++;
        if (dht11_drive_low && en) overlap_cnt++;
        if (en) begin
          en_cnt++;
          if (en_first < 0) en_first = cyc;
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (rel_cyc < 0 && !dht11_drive_low) rel_cyc = cyc;
        if (done || error) begin
          end_cyc  = cyc;
          code_end = err_code;
          busy_end = busy;
        end
        if (rel_cyc >= 0) begin
          automatic int r = cyc - rel_cyc;
          if (r < low_len) dht11_data_s = 1'b0;
          else if (r < low_len + high_len) dht11_data_s = 1'b1;
          else dht11_data_s = 1'b0;
        end
        if (mode == 1)
          start = (cyc == 100) || (rel_cyc >= 0 && cyc == rel_cyc + 5) ||
                  (en_first >= 0 && cyc == en_first + 10) || (end_cyc == cyc);
      end
      @(posedge clk); #1;
    end
    check("run_finished", finished, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dht11_data_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drive_low", dht11_drive_low, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal read: 16-tick low, 16-tick high response
    run_read(16, 16, 0);
    check("nom_drive_cycles", drive_cnt, 3516);
    check("nom_release_cyc", rel_cyc, 3516);
    check("nom_busy_start", busy_first, 1);
    check("nom_code_start", code_first, 0);
    check("nom_en_first", en_first, 3549);
    check("nom_en_cycles", en_cnt, 1000);
    check("nom_end_cyc", end_cyc, 4549);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_err_cnt", err_cnt, 0);
    check("nom_err_code", code_end, 0);
    check("nom_busy_end", busy_end, 0);
    check("nom_overlap", overlap_cnt, 0);
    check("nom_post_drive1", post_drive1, 0);
    check("nom_post_drive2", post_drive2, 0);

    // No response: bus stays high after release
    run_read(0, NEVER, 0);
    check("nr_end_cyc", end_cyc, 3524);
    check("nr_err_cnt", err_cnt, 1);
    check("nr_done_cnt", done_cnt, 0);
    check("nr_err_code", code_end, 1);
    check("nr_en_cycles", en_cnt, 0);
    check("nr_busy_end", busy_end, 0);
    repeat (5) @(posedge clk);
    #0;
    check("nr_code_held", err_code, 1);
    check("nr_idle_busy", busy, 0);

    // Short response-low (5 ticks)
    run_read(5, 16, 0);
    check("sl_code_start", code_first, 0);
    check("sl_end_cyc", end_cyc, 3522);
    check("sl_err_cnt", err_cnt, 1);
    check("sl_err_code", code_end, 2);

    // Stuck low after release
    run_read(NEVER, 0, 0);
    check("stk_end_cyc", end_cyc, 3537);
    check("stk_err_code", code_end, 2);
    check("stk_en_cycles", en_cnt, 0);

    // Response-high too long (30 ticks)
    run_read(16, 30, 0);
    check("bh_end_cyc", end_cyc, 3553);
    check("bh_err_cnt", err_cnt, 1);
    check("bh_err_code", code_end, 3);
    check("bh_en_cycles", en_cnt, 0);

    // Async reset in the middle of the start pulse
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    check("ar_drive_before", dht11_drive_low, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_drive_low", dht11_drive_low, 0);
    check("ar_busy", busy, 0);
    check("ar_en", en, 0);
    check("ar_err_code", err_code, 0);
    check("ar_done_error", {30'd0, done, error}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_read(0, NEVER, 0);
    check("ar_new_drive_cycles", drive_cnt, 3516);
    check("ar_new_err_code", code_end, 1);

    // Start pulses while busy are ignored
    run_read(16, 16, 1);
    check("pl_done_cnt", done_cnt, 1);
    check("pl_en_cycles", en_cnt, 1000);
    check("pl_end_cyc", end_cyc, 4549);
    check("pl_post_drive1", post_drive1, 0);
    check("pl_post_drive2", post_drive2, 0);

    // Start held high: next read accepted on the first idle cycle
    run_read(16, 16, 2);
    check("hd_end_cyc", end_cyc, 4549);
    check("hd_done_cnt", done_cnt, 1);
    check("hd_post_drive1", post_drive1, 0);
    check("hd_post_drive2", post_drive2, 1);
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
